// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, ALU and response signal bundle for alu_arbiter
// slave: arbiter view; master: issue logic / ALU / consumer view.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_d1;
  logic [WIDTH-1:0] req0_d2;
  logic [CW-1:0]    req0_ctrl;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_d1;
  logic [WIDTH-1:0] req1_d2;
  logic [CW-1:0]    req1_ctrl;
  logic [WIDTH-1:0] alu_d1;
  logic [WIDTH-1:0] alu_d2;
  logic [CW-1:0]    alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_id;
  logic             rsp_illegal;

  modport slave (
    input  req0_valid, req0_d1, req0_d2, req0_ctrl,
    output req0_ready,
    input  req1_valid, req1_d1, req1_d2, req1_ctrl,
    output req1_ready,
    output alu_d1, alu_d2, alu_control,
    input  alu_result,
    output rsp_valid, rsp_result, rsp_id, rsp_illegal,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_d1, req0_d2, req0_ctrl,
    input  req0_ready,
    output req1_valid, req1_d1, req1_d2, req1_ctrl,
    input  req1_ready,
    input  alu_d1, alu_d2, alu_control,
    output alu_result,
    input  rsp_valid, rsp_result, rsp_id, rsp_illegal,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one external ALU between two requesters
// One operation in flight: IDLE accepts, EXEC captures the ALU result, RESP holds it
// until the consumer takes it. Illegal control codes yield result 0 and rsp_illegal.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CW    = 4
) (
  input  logic clk,
  input  logic rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic             ctrl_legal;
  logic [WIDTH-1:0] d1_q;
  logic [WIDTH-1:0] d2_q;
  logic [CW-1:0]    ctrl_q;
  logic [WIDTH-1:0] result_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic             rsp_illegal_q;

  // Pick the requester: a lone valid wins, a tie goes to the one not served last.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready is withheld during reset so nothing is accepted that reset would drop.
  assign accept         = (state == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = accept && !grant;
  assign bus.req1_ready = accept && grant;

  // Decode the latched control code; anything outside the ALU's encodings is illegal.
  always_comb begin
    ctrl_legal = 1'b0;
    case (ctrl_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b0110, 4'b0111,
      4'b1000, 4'b1101: ctrl_legal = 1'b1;
      default:          ctrl_legal = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: accept -> one execute cycle -> hold response until taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch on accept, result capture in EXEC, response retire in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant    <= 1'b1;
      d1_q          <= '0;
      d2_q          <= '0;
      ctrl_q        <= '0;
      result_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        d1_q       <= grant ? bus.req1_d1   : bus.req0_d1;
        d2_q       <= grant ? bus.req1_d2   : bus.req0_d2;
        ctrl_q     <= grant ? bus.req1_ctrl : bus.req0_ctrl;
        rsp_id_q   <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        // The ALU output is undefined for illegal codes, so it is masked, not passed.
        result_q      <= ctrl_legal ? bus.alu_result : '0;
        rsp_illegal_q <= !ctrl_legal;
        rsp_valid_q   <= 1'b1;
      end
      if (state == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.alu_d1      = d1_q;
  assign bus.alu_d2      = d2_q;
  assign bus.alu_control = ctrl_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = result_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_illegal = rsp_illegal_q;

endmodule
